// File: rtl/pixel_scene_ctrl_if.sv
// Scan, image-ROM, palette-decoder and pixel-out signals of the scene controller.
// The display side drives the master modport and the controller takes the slave modport.
interface pixel_scene_ctrl_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        frame_start;
    logic        start_game;
    logic        back_to_menu;
    logic [16:0] rom_addr;
    logic        rom_sel;
    logic [4:0]  rom_idx;
    logic [4:0]  pre_bg_pixel;
    logic [4:0]  pre_menu_pixel;
    logic [11:0] bg_pixel;
    logic [11:0] menu_pixel;
    logic [11:0] vga_rgb;
    logic [1:0]  scene;
    logic        busy;

    modport master (
        output h_cnt, v_cnt, valid, frame_start, start_game, back_to_menu,
        output rom_idx, bg_pixel, menu_pixel,
        input  rom_addr, rom_sel, pre_bg_pixel, pre_menu_pixel, vga_rgb, scene, busy
    );

    modport slave (
        input  h_cnt, v_cnt, valid, frame_start, start_game, back_to_menu,
        input  rom_idx, bg_pixel, menu_pixel,
        output rom_addr, rom_sel, pre_bg_pixel, pre_menu_pixel, vga_rgb, scene, busy
    );
endinterface

// File: rtl/pixel_scene_ctrl.sv
// Menu/game scene sequencer with per-frame fade, plus the VGA pixel path:
// scan -> ROM address -> palette routing -> brightness scaling -> vga_rgb.

module pixel_scene_lane (
    input  logic [3:0] c_in,
    input  logic [4:0] level,
    output logic [3:0] c_out
);
    logic [8:0] prod;

    assign prod  = 9'(c_in) * 9'(level);
    assign c_out = 4'(prod >> 4);
endmodule

module pixel_scene_ctrl #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int ROM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pixel_scene_ctrl_if.slave bus
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int STAGES = ROM_LAT;
    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        GAME     = 2'd1,
        FADE_OUT = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic       tgt, tgt_n;
    logic       shown, shown_n;
    logic [4:0] level, level_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MENU;
            tgt   <= 1'b1;
            shown <= 1'b1;
            level <= 5'd16;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            shown <= shown_n;
            level <= level_n;
        end
    end

    // Requests are only looked at in the settled scenes, so a request that
    // coincides with frame_start never also steps the fade.
    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        shown_n = shown;
        level_n = level;
        case (state)
            MENU: if (bus.start_game) begin
                state_n = FADE_OUT;
                tgt_n   = 1'b0;
            end
            GAME: if (bus.back_to_menu) begin
                state_n = FADE_OUT;
                tgt_n   = 1'b1;
            end
            FADE_OUT: if (bus.frame_start) begin
                if (level != 5'd0) begin
                    level_n = level - 5'd1;
                end else begin
                    shown_n = tgt;
                    state_n = FADE_IN;
                end
            end
            FADE_IN: if (bus.frame_start) begin
                level_n = level + 5'd1;
                if (level == 5'd15) state_n = tgt ? MENU : GAME;
            end
            default: state_n = MENU;
        endcase
    end

    assign bus.scene   = state;
    assign bus.busy    = (state == FADE_OUT) || (state == FADE_IN);
    assign bus.rom_sel = shown;

    logic [ADDR_W-1:0] addr_n;

    assign addr_n = ADDR_W'(bus.v_cnt >> 1) * ADDR_W'(IMG_W) + ADDR_W'(bus.h_cnt >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         bus.rom_addr <= '0;
        else if (bus.valid) bus.rom_addr <= 17'(addr_n);
    end

    // Entry 0 lines up with rom_addr; entry STAGES lines up with rom_idx.
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] shown_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            shown_pipe <= '1;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:0], bus.valid};
            shown_pipe <= {shown_pipe[STAGES-1:0], shown};
        end
    end

    logic vld_al, shown_al;

    assign vld_al   = vld_pipe[STAGES];
    assign shown_al = shown_pipe[STAGES];

    assign bus.pre_bg_pixel   = (vld_al && !shown_al) ? bus.rom_idx : 5'd0;
    assign bus.pre_menu_pixel = (vld_al &&  shown_al) ? bus.rom_idx : 5'd0;

    logic [NUM_CH-1:0][3:0] c_src;
    logic [NUM_CH-1:0][3:0] scaled;

    assign c_src = shown_al ? bus.menu_pixel : bus.bg_pixel;

    // level is safe to use unregistered: it only moves on frame_start, in blank.
    pixel_scene_lane u_lane [NUM_CH-1:0] (
        .c_in  (c_src),
        .level (level),
        .c_out (scaled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.vga_rgb <= '0;
        else        bus.vga_rgb <= vld_al ? scaled : 12'd0;
    end
endmodule

// File: tb/tb_pixel_scene_ctrl.sv
// Directed bench for pixel_scene_ctrl: scan line, fades both ways, scaling,
// ignored/simultaneous requests and reset in the middle of a fade.
module tb_pixel_scene_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pixel_scene_ctrl_if bus ();

    pixel_scene_ctrl #(.IMG_W(320), .IMG_H(240), .ROM_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Image ROM stand-in: two-cycle latency, content = low 5 address bits.
    logic [4:0] a_q1, a_q2;
    always_ff @(posedge clk) begin
        a_q1 <= bus.rom_addr[4:0];
        a_q2 <= a_q1;
    end
    assign bus.rom_idx = a_q2;

    function automatic logic [11:0] dec_menu(input logic [4:0] p);
        return {p[3:0], ~p[3:0], p[3:0] ^ {3'b0, p[4]}};
    endfunction

    function automatic logic [11:0] dec_bg(input logic [4:0] p);
        return {p[3:0], p[3:0], p[3:0] ^ {3'b0, p[4]}};
    endfunction

    assign bus.menu_pixel = dec_menu(bus.pre_menu_pixel);
    assign bus.bg_pixel   = dec_bg(bus.pre_bg_pixel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic chk_state(input string tag, input logic [1:0] sc, input logic bz, input logic sel);
        chk({tag, "/scene"}, 32'(bus.scene), 32'(sc));
        chk({tag, "/busy"}, 32'(bus.busy), 32'(bz));
        chk({tag, "/rom_sel"}, 32'(bus.rom_sel), 32'(sel));
    endtask

    // One active pixel: checks the address, decoder routing and scaled output.
    task automatic pix(input int h, input int v, input logic sh, input logic [11:0] exp, input string tag);
        logic [16:0] a;
        a = 17'((v / 2) * 320 + h / 2);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
        bus.valid = 1'b1;
        tick();
        chk({tag, "/addr"}, 32'(bus.rom_addr), 32'(a));
        bus.valid = 1'b0;
        tick();
        tick();
        chk({tag, "/pre_sel"}, 32'(sh ? bus.pre_menu_pixel : bus.pre_bg_pixel), 32'(a[4:0]));
        chk({tag, "/pre_off"}, 32'(sh ? bus.pre_bg_pixel : bus.pre_menu_pixel), 32'd0);
        tick();
        chk({tag, "/rgb"}, 32'(bus.vga_rgb), 32'(exp));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.h_cnt        = '0;
        bus.v_cnt        = '0;
        bus.valid        = 1'b0;
        bus.frame_start  = 1'b0;
        bus.start_game   = 1'b0;
        bus.back_to_menu = 1'b0;
        tick();
        tick();
        chk_state("reset", 2'd0, 1'b0, 1'b1);
        chk("reset/addr", 32'(bus.rom_addr), 32'd0);
        chk("reset/rgb", 32'(bus.vga_rgb), 32'd0);
        chk("reset/pre_bg", 32'(bus.pre_bg_pixel), 32'd0);
        chk("reset/pre_menu", 32'(bus.pre_menu_pixel), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full active line 0 in MENU at level 16.
        for (int i = 0; i < 640; i++) begin
            bus.h_cnt = 10'(i);
            bus.v_cnt = 10'd0;
            bus.valid = 1'b1;
            tick();
            chk("line/addr", 32'(bus.rom_addr), 32'(i / 2));
            chk("line/rgb", 32'(bus.vga_rgb), 32'((i < 3) ? 12'h000 : dec_menu(5'((i - 3) / 2))));
        end
        bus.valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("line/tail_rgb", 32'(bus.vga_rgb), 32'(dec_menu(5'((637 + j) / 2))));
        end
        tick();
        chk("line/blank_rgb", 32'(bus.vga_rgb), 32'd0);
        chk("line/addr_held", 32'(bus.rom_addr), 32'd319);
        chk_state("line", 2'd0, 1'b0, 1'b1);

        bus.back_to_menu = 1'b1;
        tick();
        bus.back_to_menu = 1'b0;
        chk_state("b2m_in_menu", 2'd0, 1'b0, 1'b1);
        pix(30, 0, 1'b1, 12'hF0F, "menu_l16");

        // Request and frame_start together: request wins, no level step.
        bus.start_game  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.start_game  = 1'b0;
        bus.frame_start = 1'b0;
        chk_state("fo_enter", 2'd2, 1'b1, 1'b1);
        pix(30, 0, 1'b1, 12'hF0F, "fo_l16");
        frame();
        pix(30, 0, 1'b1, 12'hE0E, "fo_l15");
        frames(15);
        chk_state("fo_l0", 2'd2, 1'b1, 1'b1);
        pix(30, 0, 1'b1, 12'h000, "fo_l0");
        frame();
        chk_state("fi_enter", 2'd3, 1'b1, 1'b0);
        pix(30, 0, 1'b0, 12'h000, "fi_l0");
        frames(8);
        pix(30, 0, 1'b0, 12'h777, "fi_l8");

        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
        chk_state("sg_in_fi", 2'd3, 1'b1, 1'b0);
        frames(7);
        chk_state("fi_l15", 2'd3, 1'b1, 1'b0);
        pix(30, 0, 1'b0, 12'hEEE, "fi_l15");
        frame();
        chk_state("game", 2'd1, 1'b0, 1'b0);
        pix(30, 0, 1'b0, 12'hFFF, "game_l16");
        pix(639, 479, 1'b0, 12'hFFE, "max_addr");
        pix(5, 3, 1'b0, 12'h222, "addr_322");

        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
        chk_state("sg_in_game", 2'd1, 1'b0, 1'b0);

        // Game back to menu, stopping at level 5 of the fade-in.
        bus.back_to_menu = 1'b1;
        tick();
        bus.back_to_menu = 1'b0;
        chk_state("to_menu", 2'd2, 1'b1, 1'b0);
        frames(16);
        chk_state("to_menu_l0", 2'd2, 1'b1, 1'b0);
        frame();
        chk_state("to_menu_fi", 2'd3, 1'b1, 1'b1);
        frames(5);
        pix(30, 0, 1'b1, 12'h404, "fi_l5");

        bus.h_cnt = 10'd30;
        bus.v_cnt = 10'd0;
        bus.valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst/rgb", 32'(bus.vga_rgb), 32'h404);
        rst_n = 1'b0;
        #1;
        chk_state("mid_rst", 2'd0, 1'b0, 1'b1);
        chk("mid_rst/rgb", 32'(bus.vga_rgb), 32'd0);
        chk("mid_rst/addr", 32'(bus.rom_addr), 32'd0);
        bus.valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pix(30, 0, 1'b1, 12'hF0F, "post_rst_l16");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
